// File: rtl/instr_fetch_unit.sv
// Fetch stage: reads the PC, runs a req/ack read to instruction memory, holds the
// returned word for the decoder under valid/ready, and strobes the PC forward.
module instr_fetch_unit #(
    parameter int                 ADDR_W      = 16,
    parameter int                 INSTR_W     = 16,
    parameter logic [INSTR_W-1:0] HALT_OPCODE = 16'hFFFF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               flush,
    input  logic [ADDR_W-1:0]  pc_in,
    output logic               pc_inc,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] ir_out,
    output logic               ir_valid,
    input  logic               ir_ready,
    output logic               halted,
    output logic [15:0]        fetch_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_DRAIN,
        S_HOLD,
        S_HALTED
    } state_t;

    state_t state_reg;

    // The PC steps on the same edge that captures the IR, so a later HOLD->REQ sees the next address.
    assign pc_inc = (state_reg == S_REQ) && imem_ack && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            imem_req    <= 1'b0;
            imem_addr   <= '0;
            ir_out      <= '0;
            ir_valid    <= 1'b0;
            halted      <= 1'b0;
            fetch_count <= 16'd0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (en && !flush) begin
                        state_reg <= S_REQ;
                        imem_req  <= 1'b1;
                        imem_addr <= pc_in;
                    end
                end
                S_REQ: begin
                    if (imem_ack) begin
                        imem_req <= 1'b0;
                        if (!flush) begin
                            ir_out    <= imem_rdata;
                            ir_valid  <= 1'b1;
                            state_reg <= S_HOLD;
                        end else begin
                            state_reg <= S_IDLE;
                        end
                    end else if (flush) begin
                        state_reg <= S_DRAIN;
                    end
                end
                // An issued request must see its ack before it can be dropped.
                S_DRAIN: begin
                    if (imem_ack) begin
                        imem_req  <= 1'b0;
                        state_reg <= S_IDLE;
                    end
                end
                S_HOLD: begin
                    if (flush) begin
                        ir_valid  <= 1'b0;
                        state_reg <= S_IDLE;
                    end else if (ir_ready) begin
                        ir_valid    <= 1'b0;
                        fetch_count <= fetch_count + 16'd1;
                        if (ir_out == HALT_OPCODE) begin
                            halted    <= 1'b1;
                            state_reg <= S_HALTED;
                        end else if (en) begin
                            state_reg <= S_REQ;
                            imem_req  <= 1'b1;
                            imem_addr <= pc_in;
                        end else begin
                            state_reg <= S_IDLE;
                        end
                    end
                end
                S_HALTED: begin
                    state_reg <= S_HALTED;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: memory responder, PC model and IR scoreboard in one
// monitor process; scenario tasks drive en/flush/ir_ready and check milestones.
module tb_instr_fetch_unit;

    logic        clk = 1'b0, rst = 1'b0, en = 1'b0, flush = 1'b0, ir_ready = 1'b0, imem_ack = 1'b0;
    logic [15:0] pc_in = 16'h0, imem_rdata = 16'h0;
    logic        pc_inc, imem_req, ir_valid, halted;
    logic [15:0] imem_addr, ir_out, fetch_count;

    int          checks = 0, errors = 0;
    int          wait_states = 0;
    logic [15:0] flush_target = 16'h0, exp_count = 16'h0;
    logic [15:0] mem_q[$], exp_addr_q[$], exp_ir_q[$];
    int          acc_cyc_q[$];
    int          cyc = 0, pc_inc_cnt = 0, req_cycles = 0, valid_cycles = 0;
    logic        draining = 1'b0;

    instr_fetch_unit #(.ADDR_W(16), .INSTR_W(16), .HALT_OPCODE(16'hFFFF)) dut (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .pc_in(pc_in), .pc_inc(pc_inc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .ir_out(ir_out), .ir_valid(ir_valid), .ir_ready(ir_ready), .halted(halted),
        .fetch_count(fetch_count)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    // Memory responder, PC register model and scoreboard; inputs change at negedge,
    // everything is sampled 2 time units later, models advance just after posedge.
    initial begin : monitor
        int          wcnt;
        logic        s_cap, s_acc, s_flush, drain_next, prev_req, prev_valid;
        logic [15:0] prev_addr, prev_ir, want;
        wcnt = 0; s_cap = 0; s_acc = 0; s_flush = 0; drain_next = 0;
        prev_req = 0; prev_valid = 0; prev_addr = 0; prev_ir = 0; want = 0;
        forever begin
            @(negedge clk);
            if (rst || !imem_req) begin
                imem_ack = 1'b0;
                wcnt = 0;
            end else if (wcnt >= wait_states) begin
                imem_ack = 1'b1;
                wcnt = 0;
                if (mem_q.size() > 0) imem_rdata = mem_q.pop_front();
                else imem_rdata = 16'hDEAD;
            end else begin
                imem_ack = 1'b0;
                wcnt++;
            end
            #2;
            s_flush = flush; s_cap = 0; s_acc = 0; drain_next = draining;
            if (rst) begin
                mem_q.delete(); exp_addr_q.delete(); exp_ir_q.delete();
                exp_count = 16'h0; draining = 1'b0; drain_next = 1'b0;
                prev_req = 0; prev_valid = 0;
            end else begin
                s_cap = imem_req & imem_ack & ~s_flush & ~draining;
                s_acc = ir_valid & ir_ready & ~s_flush;
                checks++;
                if (pc_inc !== s_cap) begin
                    errors++; $display("FAIL pc_inc cyc=%0d got %b want %b", cyc, pc_inc, s_cap);
                end
                if (s_cap) begin
                    exp_ir_q.push_back(imem_rdata);
                    pc_inc_cnt++;
                end
                if (imem_req && !prev_req) begin
                    checks++;
                    if (exp_addr_q.size() == 0) begin
                        errors++; $display("FAIL unexpected_req cyc=%0d addr %h want none", cyc, imem_addr);
                    end else begin
                        want = exp_addr_q.pop_front();
                        if (imem_addr !== want) begin
                            errors++; $display("FAIL imem_addr cyc=%0d got %h want %h", cyc, imem_addr, want);
                        end
                    end
                end
                if (imem_req && prev_req) begin
                    checks++;
                    if (imem_addr !== prev_addr) begin
                        errors++; $display("FAIL addr_stable cyc=%0d got %h want %h", cyc, imem_addr, prev_addr);
                    end
                end
                if (ir_valid && prev_valid) begin
                    checks++;
                    if (ir_out !== prev_ir) begin
                        errors++; $display("FAIL ir_stable cyc=%0d got %h want %h", cyc, ir_out, prev_ir);
                    end
                end
                if (imem_req) req_cycles++;
                if (ir_valid) valid_cycles++;
                if (s_acc) begin
                    checks++;
                    if (exp_ir_q.size() == 0) begin
                        errors++; $display("FAIL ir_unexpected cyc=%0d got %h want none", cyc, ir_out);
                    end else begin
                        want = exp_ir_q.pop_front();
                        if (ir_out !== want) begin
                            errors++; $display("FAIL ir_out cyc=%0d got %h want %h", cyc, ir_out, want);
                        end
                    end
                    acc_cyc_q.push_back(cyc);
                    $display("accept cyc=%0d ir=%h count=%0d", cyc, ir_out, exp_count + 16'd1);
                end else if (ir_valid && s_flush && exp_ir_q.size() > 0) begin
                    void'(exp_ir_q.pop_front());
                end
                checks++;
                if (fetch_count !== exp_count) begin
                    errors++; $display("FAIL fetch_count cyc=%0d got %0d want %0d", cyc, fetch_count, exp_count);
                end
                if (!draining && imem_req && s_flush && !imem_ack) drain_next = 1'b1;
                if (draining && imem_ack) drain_next = 1'b0;
                prev_req = imem_req; prev_valid = ir_valid; prev_addr = imem_addr; prev_ir = ir_out;
            end
            @(posedge clk); #1;
            cyc++;
            if (!rst) begin
                if (s_flush) pc_in = flush_target;
                else if (s_cap) pc_in = pc_in + 16'd1;
                if (s_acc) exp_count = exp_count + 16'd1;
                draining = drain_next;
            end
        end
    end

    task automatic wait_pcinc(input int target, output bit ok);
        ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk); #3;
            if (pc_inc_cnt >= target) ok = 1;
        end
    endtask

    task automatic wait_valid(output bit ok);
        ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk); #3;
            if (ir_valid === 1'b1) ok = 1;
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({imem_req, imem_addr, ir_out, ir_valid, halted, fetch_count, pc_inc} !== 52'h0) begin
            errors++; $display("FAIL reset_outputs got req=%b addr=%h ir=%h v=%b h=%b cnt=%0d inc=%b want all 0",
                               imem_req, imem_addr, ir_out, ir_valid, halted, fetch_count, pc_inc);
        end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_sequential();
        bit ok;
        int base_inc, base_acc, n;
        @(negedge clk);
        pc_in = 16'h0010; wait_states = 0; ir_ready = 1'b1;
        mem_q = '{16'h1111, 16'h2222, 16'h3333};
        exp_addr_q = '{16'h0010, 16'h0011, 16'h0012};
        base_inc = pc_inc_cnt; base_acc = acc_cyc_q.size();
        en = 1'b1;
        @(posedge clk); #3;
        checks++;
        if (imem_req !== 1'b1) begin errors++; $display("FAIL seq_req_latency got %b want 1", imem_req); end
        @(posedge clk); #3;
        checks++;
        if (ir_valid !== 1'b1 || ir_out !== 16'h1111) begin
            errors++; $display("FAIL seq_valid_latency got v=%b ir=%h want v=1 ir=1111", ir_valid, ir_out);
        end
        wait_pcinc(base_inc + 3, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL seq_timeout got %0d acks want 3", pc_inc_cnt - base_inc); end
        @(negedge clk); en = 1'b0;
        repeat (3) @(negedge clk);
        #3;
        checks++;
        if (fetch_count !== 16'd3) begin errors++; $display("FAIL seq_count got %0d want 3", fetch_count); end
        checks++;
        if (pc_inc_cnt - base_inc !== 3) begin errors++; $display("FAIL seq_pc_inc got %0d want 3", pc_inc_cnt - base_inc); end
        n = acc_cyc_q.size();
        checks++;
        if (n - base_acc !== 3) begin
            errors++; $display("FAIL seq_accepts got %0d want 3", n - base_acc);
        end else begin
            checks++;
            if (acc_cyc_q[n-1] - acc_cyc_q[n-2] !== 2 || acc_cyc_q[n-2] - acc_cyc_q[n-3] !== 2) begin
                errors++; $display("FAIL seq_throughput got gaps %0d,%0d want 2,2",
                                   acc_cyc_q[n-2] - acc_cyc_q[n-3], acc_cyc_q[n-1] - acc_cyc_q[n-2]);
            end
        end
        checks++;
        if (exp_addr_q.size() != 0 || exp_ir_q.size() != 0 || imem_req !== 1'b0) begin
            errors++; $display("FAIL seq_drained got addr_q=%0d ir_q=%0d req=%b want 0,0,0",
                               exp_addr_q.size(), exp_ir_q.size(), imem_req);
        end
    endtask

    task automatic test_wait_backpressure();
        bit ok;
        int base_req, base_valid;
        @(negedge clk);
        pc_in = 16'h0040; wait_states = 3; ir_ready = 1'b0;
        mem_q.push_back(16'h1234); exp_addr_q.push_back(16'h0040);
        base_req = req_cycles; base_valid = valid_cycles;
        en = 1'b1;
        @(negedge clk); en = 1'b0;
        wait_valid(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL wait_timeout got v=%b want 1", ir_valid); end
        repeat (4) @(negedge clk);
        ir_ready = 1'b1;
        @(negedge clk); ir_ready = 1'b0;
        repeat (2) @(negedge clk);
        #3;
        checks++;
        if (req_cycles - base_req !== 4) begin errors++; $display("FAIL wait_req_cycles got %0d want 4", req_cycles - base_req); end
        checks++;
        if (valid_cycles - base_valid !== 5) begin errors++; $display("FAIL wait_valid_cycles got %0d want 5", valid_cycles - base_valid); end
        checks++;
        if (fetch_count !== 16'd4) begin errors++; $display("FAIL wait_count got %0d want 4", fetch_count); end
    endtask

    task automatic test_flush_hold();
        bit ok;
        int base_inc;
        @(negedge clk);
        pc_in = 16'h0050; wait_states = 0; ir_ready = 1'b0;
        mem_q = '{16'hAAAA, 16'h5555};
        exp_addr_q = '{16'h0050, 16'h0024};
        base_inc = pc_inc_cnt;
        en = 1'b1;
        wait_valid(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL fh_timeout got v=%b want 1", ir_valid); end
        @(negedge clk); flush = 1'b1; flush_target = 16'h0024;
        @(posedge clk); #3;
        checks++;
        if (ir_valid !== 1'b0 || fetch_count !== 16'd4 || imem_req !== 1'b0) begin
            errors++; $display("FAIL fh_drop got v=%b cnt=%0d req=%b want v=0 cnt=4 req=0", ir_valid, fetch_count, imem_req);
        end
        @(negedge clk); flush = 1'b0; ir_ready = 1'b1;
        wait_pcinc(base_inc + 2, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL fh_refetch_timeout got %0d acks want 2", pc_inc_cnt - base_inc); end
        @(negedge clk); en = 1'b0;
        repeat (3) @(negedge clk);
        #3;
        checks++;
        if (fetch_count !== 16'd5 || exp_ir_q.size() != 0 || exp_addr_q.size() != 0) begin
            errors++; $display("FAIL fh_end got cnt=%0d ir_q=%0d addr_q=%0d want 5,0,0", fetch_count, exp_ir_q.size(), exp_addr_q.size());
        end
    endtask

    task automatic test_flush_req();
        bit ok;
        int base_inc, base_req;
        @(negedge clk);
        pc_in = 16'h0060; wait_states = 2; ir_ready = 1'b1;
        mem_q = '{16'hBBBB, 16'h7777};
        exp_addr_q = '{16'h0060, 16'h0078};
        base_inc = pc_inc_cnt; base_req = req_cycles;
        en = 1'b1;
        @(negedge clk); en = 1'b0; flush = 1'b1; flush_target = 16'h0070;
        @(posedge clk); #3;
        checks++;
        if (imem_req !== 1'b1) begin errors++; $display("FAIL fr_drain1 got req=%b want 1", imem_req); end
        @(negedge clk); flush_target = 16'h0078;
        @(posedge clk); #3;
        checks++;
        if (imem_req !== 1'b1) begin errors++; $display("FAIL fr_drain2 got req=%b want 1", imem_req); end
        @(negedge clk); flush = 1'b0;
        @(posedge clk); #3;
        checks++;
        if (imem_req !== 1'b0 || ir_valid !== 1'b0) begin
            errors++; $display("FAIL fr_discard got req=%b v=%b want 0,0", imem_req, ir_valid);
        end
        checks++;
        if (pc_inc_cnt - base_inc !== 0 || req_cycles - base_req !== 3) begin
            errors++; $display("FAIL fr_no_inc got incs=%0d req_cycles=%0d want 0,3", pc_inc_cnt - base_inc, req_cycles - base_req);
        end
        wait_states = 0;
        @(negedge clk); en = 1'b1;
        wait_pcinc(base_inc + 1, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL fr_refetch_timeout got %0d acks want 1", pc_inc_cnt - base_inc); end
        @(negedge clk); en = 1'b0;
        repeat (3) @(negedge clk);
        #3;
        checks++;
        if (fetch_count !== 16'd6 || exp_addr_q.size() != 0) begin
            errors++; $display("FAIL fr_end got cnt=%0d addr_q=%0d want 6,0", fetch_count, exp_addr_q.size());
        end
    endtask

    task automatic test_halt();
        bit ok;
        int base_inc;
        @(negedge clk);
        pc_in = 16'h0080; wait_states = 0; ir_ready = 1'b1;
        mem_q.push_back(16'hFFFF); exp_addr_q.push_back(16'h0080);
        base_inc = pc_inc_cnt;
        en = 1'b1;
        wait_pcinc(base_inc + 1, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL halt_timeout got %0d acks want 1", pc_inc_cnt - base_inc); end
        @(posedge clk); #3;
        checks++;
        if (ir_valid !== 1'b1 || ir_out !== 16'hFFFF || halted !== 1'b0) begin
            errors++; $display("FAIL halt_deliver got v=%b ir=%h h=%b want 1,ffff,0", ir_valid, ir_out, halted);
        end
        @(posedge clk); #3;
        checks++;
        if (halted !== 1'b1 || ir_valid !== 1'b0 || fetch_count !== 16'd7) begin
            errors++; $display("FAIL halt_enter got h=%b v=%b cnt=%0d want 1,0,7", halted, ir_valid, fetch_count);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); flush = (i == 2); flush_target = 16'h0090;
            @(posedge clk); #3;
            checks++;
            if (imem_req !== 1'b0 || halted !== 1'b1) begin
                errors++; $display("FAIL halt_stay i=%0d got req=%b h=%b want 0,1", i, imem_req, halted);
            end
        end
        @(negedge clk); flush = 1'b0; rst = 1'b1;
        #1;
        checks++;
        if (halted !== 1'b0 || fetch_count !== 16'd0) begin
            errors++; $display("FAIL halt_rst got h=%b cnt=%0d want 0,0", halted, fetch_count);
        end
        @(negedge clk); @(negedge clk);
        rst = 1'b0; en = 1'b0;
    endtask

    task automatic test_count_wrap();
        bit ok;
        int base_inc;
        @(negedge clk);
        force dut.fetch_count = 16'hFFFF;
        exp_count = 16'hFFFF;
        @(negedge clk);
        release dut.fetch_count;
        pc_in = 16'h00F0; wait_states = 0; ir_ready = 1'b1;
        mem_q = '{16'h9999, 16'h4242};
        exp_addr_q = '{16'h00F0, 16'h00F1};
        base_inc = pc_inc_cnt;
        @(negedge clk); en = 1'b1;
        wait_pcinc(base_inc + 1, ok);
        wait_states = 5;
        checks++;
        if (!ok) begin errors++; $display("FAIL wrap_timeout got %0d acks want 1", pc_inc_cnt - base_inc); end
        @(posedge clk); #3;
        checks++;
        if (fetch_count !== 16'hFFFF) begin errors++; $display("FAIL wrap_pre got %h want ffff", fetch_count); end
        @(posedge clk); #3;
        checks++;
        if (fetch_count !== 16'h0000 || imem_req !== 1'b1) begin
            errors++; $display("FAIL wrap_post got cnt=%h req=%b want 0000,1", fetch_count, imem_req);
        end
        // Mid-cycle reset while the second request is outstanding.
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({imem_req, imem_addr, ir_out, ir_valid, halted, fetch_count, pc_inc} !== 52'h0) begin
            errors++; $display("FAIL async_rst got req=%b addr=%h ir=%h v=%b h=%b cnt=%0d inc=%b want all 0",
                               imem_req, imem_addr, ir_out, ir_valid, halted, fetch_count, pc_inc);
        end
        @(negedge clk); @(negedge clk);
        rst = 1'b0; en = 1'b0; ir_ready = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_wait_backpressure();
        test_flush_hold();
        test_flush_req();
        test_halt();
        test_count_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
